// File: rtl/ram_hs_bank.sv
// ram_hs_bank: a banked single-port SRAM with valid/ready write, read-address and read-data channels.
// Define RAM_HS_WSTRB_EN to add per-slice write strobes. rst_i asserts asynchronously and must be released synchronously to clk_i.
module ram_hs_bank #(
   parameter int SRAM_BIT  = 128,
   parameter int SRAM_BYTE = 1,
   parameter int SRAM_WORD = 64,
   parameter int NUM_BANK  = 2,
   parameter int RD_LAT    = 1,
   localparam int SRAM_WIDTH = SRAM_BIT * SRAM_BYTE,
   localparam int ROW_BIT    = $clog2(SRAM_WORD),
   localparam int BANK_BIT   = $clog2(NUM_BANK),
   localparam int ADDR_BIT   = ROW_BIT + BANK_BIT,
   localparam int CAP        = RD_LAT + 1,
   localparam int CNT_BIT    = $clog2(CAP + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wvalid_i,
   output logic                  wready_o,
   input  logic [ADDR_BIT-1:0]   waddr_i,
   input  logic [SRAM_WIDTH-1:0] wdata_i,
`ifdef RAM_HS_WSTRB_EN
   input  logic [SRAM_BYTE-1:0]  wstrb_i,
`endif
   input  logic                  arvalid_i,
   output logic                  arready_o,
   input  logic [ADDR_BIT-1:0]   araddr_i,
   output logic                  rvalid_o,
   input  logic                  rready_i,
   output logic [SRAM_WIDTH-1:0] rdata_o,
   output logic [CNT_BIT-1:0]    rd_cnt_o
);

   localparam int BANK_W = (BANK_BIT > 0) ? BANK_BIT : 1;
   localparam int PTR_W  = $clog2(CAP);

   logic [BANK_W-1:0]     wbank, arbank;
   logic [ROW_BIT-1:0]    wrow, arrow;
   logic                  wrow_ok;
   logic [SRAM_BYTE-1:0]  wstrb_eff;
   logic                  conflict, credit_ok, ar_fire, r_fire, push;

   // Bank select lives in the low address bits so consecutive addresses alternate banks.
   generate
      if (BANK_BIT > 0) begin : g_split
         assign wbank  = waddr_i[BANK_BIT-1:0];
         assign wrow   = waddr_i[ADDR_BIT-1:BANK_BIT];
         assign arbank = araddr_i[BANK_BIT-1:0];
         assign arrow  = araddr_i[ADDR_BIT-1:BANK_BIT];
      end else begin : g_nosplit
         assign wbank  = '0;
         assign wrow   = waddr_i;
         assign arbank = '0;
         assign arrow  = araddr_i;
      end
   endgenerate

   assign wrow_ok = ({1'b0, wrow} < (ROW_BIT + 1)'(SRAM_WORD));

`ifdef RAM_HS_WSTRB_EN
   assign wstrb_eff = wstrb_i;
`else
   assign wstrb_eff = '1;
`endif

   logic [CNT_BIT-1:0] rd_cnt_q, rd_cnt_d;
   logic [CNT_BIT-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

   // The write port owns a bank for the cycle; a read to the same bank waits.
   assign conflict  = wvalid_i && (wbank == arbank);
   assign r_fire    = rvalid_o && rready_i;
   assign credit_ok = (rd_cnt_q < CNT_BIT'(CAP)) || r_fire;
   assign arready_o = credit_ok && !conflict;
   assign ar_fire   = arvalid_i && arready_o;
   assign wready_o  = 1'b1;

   logic [SRAM_WIDTH-1:0] bank_rd [NUM_BANK];

   for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
      logic [SRAM_WIDTH-1:0] mem_q [SRAM_WORD];
      logic [SRAM_WIDTH-1:0] rd_q;
      logic                  we, re;

      assign we = wvalid_i && wrow_ok && (wbank == BANK_W'(b));
      assign re = ar_fire && (arbank == BANK_W'(b));

      always_ff @(posedge clk_i) begin
         if (we) begin
            for (int s = 0; s < SRAM_BYTE; s++) begin
               if (wstrb_eff[s]) begin
                  mem_q[wrow][s*SRAM_BIT +: SRAM_BIT] <= wdata_i[s*SRAM_BIT +: SRAM_BIT];
               end
            end
         end
         if (re) begin
            rd_q <= mem_q[arrow];
         end
      end

      assign bank_rd[b] = rd_q;
   end

   logic [RD_LAT-1:0]     pv_q, pv_d;
   logic [BANK_W-1:0]     sel_q;
   logic [SRAM_WIDTH-1:0] s0_data, push_data;

   always_comb begin
      pv_d    = '0;
      pv_d[0] = ar_fire;
      for (int k = 1; k < RD_LAT; k++) begin
         pv_d[k] = pv_q[k-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (ar_fire) begin
         sel_q <= arbank;
      end
   end

   assign s0_data = bank_rd[sel_q];

   // Extra latency stages carry data unconditionally; credits guarantee the FIFO can take it.
   generate
      if (RD_LAT == 1) begin : g_lat1
         assign push_data = s0_data;
      end else begin : g_latn
         logic [SRAM_WIDTH-1:0] sd_q [RD_LAT-1];
         always_ff @(posedge clk_i) begin
            sd_q[0] <= s0_data;
            for (int k = 1; k < RD_LAT - 1; k++) begin
               sd_q[k] <= sd_q[k-1];
            end
         end
         assign push_data = sd_q[RD_LAT-2];
      end
   endgenerate

   assign push = pv_q[RD_LAT-1];

   logic [SRAM_WIDTH-1:0] fifo_q [CAP];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(CAP - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q + CNT_BIT'(push) - CNT_BIT'(r_fire);
      rd_cnt_d   = rd_cnt_q + CNT_BIT'(ar_fire) - CNT_BIT'(r_fire);
      if (push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (r_fire) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pv_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         rd_cnt_q   <= '0;
      end else begin
         pv_q       <= pv_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= push_data;
      end
   end

   assign rvalid_o = (fifo_cnt_q != '0);
   assign rdata_o  = fifo_q[rd_ptr_q];
   assign rd_cnt_o = rd_cnt_q;

endmodule

// File: tb/tb_ram_hs_bank.sv
// Randomized scoreboard bench for ram_hs_bank: stimulus pushes expected read data, a negedge monitor pops and compares.
module tb_ram_hs_bank;
   localparam int SRAM_BIT  = 16;
   localparam int SRAM_BYTE = 4;
   localparam int SRAM_WORD = 64;
   localparam int NUM_BANK  = 2;
   localparam int RD_LAT    = 2;
   localparam int W         = SRAM_BIT * SRAM_BYTE;
   localparam int ADDR_BIT  = 7;
   localparam int NADDR     = SRAM_WORD * NUM_BANK;
   localparam int CAP       = RD_LAT + 1;

   logic                 clk, rst;
   logic                 wvalid, wready, arvalid, arready, rvalid, rready;
   logic [ADDR_BIT-1:0]  waddr, araddr;
   logic [W-1:0]         wdata, rdata;
   logic [SRAM_BYTE-1:0] wstrb;
   logic [1:0]           rd_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int dut_accepts = 0;
   bit exp_fire = 0;

   typedef struct {
      logic [W-1:0] data;
      int           avail;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] ref_mem [NADDR];

   ram_hs_bank #(
      .SRAM_BIT(SRAM_BIT), .SRAM_BYTE(SRAM_BYTE), .SRAM_WORD(SRAM_WORD),
      .NUM_BANK(NUM_BANK), .RD_LAT(RD_LAT)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .wvalid_i(wvalid), .wready_o(wready), .waddr_i(waddr), .wdata_i(wdata),
`ifdef RAM_HS_WSTRB_EN
      .wstrb_i(wstrb),
`endif
      .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr),
      .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rd_cnt_o(rd_cnt)
   );

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                          input logic [SRAM_BYTE-1:0] s);
      logic [W-1:0] r;
      r = old;
      for (int i = 0; i < SRAM_BYTE; i++)
         if (s[i]) r[i*SRAM_BIT +: SRAM_BIT] = d[i*SRAM_BIT +: SRAM_BIT];
      return r;
   endfunction

   // Monitor: reference model of the handshake, read data popped whenever the DUT presents it.
   always @(negedge clk) begin
      bit erv, epop, eard;
      erv  = (sb.size() > 0) && (sb[0].avail <= cyc);
      epop = erv && rready;
      eard = ((sb.size() < CAP) || epop) &&
             !(wvalid && ((waddr % NUM_BANK) == (araddr % NUM_BANK)));
      check("rvalid", W'(rvalid), W'(erv));
      check("arready", W'(arready), W'(eard));
      check("rd_cnt", W'(rd_cnt), W'(sb.size()));
      check("wready", W'(wready), W'(1));
      if (rvalid && rready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rdata_unexpected: got %h expected no response (cycle %0d)", rdata, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rdata", rdata, e.data);
         end
      end
      exp_fire = arvalid && eard && !rst;
   end

   task automatic step();
      @(negedge clk);
      #1;
      if (exp_fire) begin
         exp_t e;
         e.data  = ref_mem[araddr];
         e.avail = cyc + 1 + RD_LAT;
         sb.push_back(e);
      end
      if (arvalid && arready && !rst) dut_accepts++;
      if (wvalid && !rst) ref_mem[waddr] = merge(ref_mem[waddr], wdata, wstrb);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int budget;
      budget = 60;
      wvalid  = 0;
      arvalid = 0;
      rready  = 1;
      while (sb.size() > 0 && budget > 0) begin
         step();
         budget--;
      end
      check("drain_left", W'(sb.size()), W'(0));
      sb.delete();
   endtask

   function automatic logic [W-1:0] rand_word();
      return {$urandom, $urandom};
   endfunction

   initial begin
      rst = 1; wvalid = 0; arvalid = 0; rready = 0;
      waddr = '0; araddr = '0; wdata = '0; wstrb = '1;
      repeat (3) @(posedge clk);
      #1;
      rst = 0;

      for (int a = 0; a < NADDR; a++) begin
         wvalid = 1; waddr = ADDR_BIT'(a); wdata = rand_word();
         step();
      end
      wvalid = 0;

      // back-to-back streaming reads
      rready = 1; dut_accepts = 0;
      for (int a = 0; a < 8; a++) begin
         arvalid = 1; araddr = ADDR_BIT'(a);
         step();
      end
      arvalid = 0;
      check("stream_accepts", W'(dut_accepts), W'(8));
      drain();

      // back-pressure: only CAP reads may be outstanding
      rready = 0; dut_accepts = 0;
      for (int i = 0; i < 6; i++) begin
         arvalid = 1; araddr = ADDR_BIT'($urandom_range(0, NADDR - 1));
         step();
      end
      arvalid = 0;
      check("bp_accepts", W'(dut_accepts), W'(CAP));
      drain();

      // bank conflict, then parallel write/read to different banks
      dut_accepts = 0;
      wvalid = 1; waddr = 7'd4; wdata = rand_word(); arvalid = 1; araddr = 7'd6;
      step();
      check("conflict_blocked", W'(dut_accepts), W'(0));
      wvalid = 0;
      step();
      check("conflict_retry", W'(dut_accepts), W'(1));
      dut_accepts = 0;
      wvalid = 1; waddr = 7'd4; wdata = rand_word(); araddr = 7'd5;
      step();
      check("parallel_accept", W'(dut_accepts), W'(1));
      wvalid = 0; araddr = 7'd4;
      step();
      drain();

      // read-after-write to the same address
      wvalid = 1; waddr = 7'd3; wdata = 64'hA5;
      step();
      wvalid = 0; arvalid = 1; araddr = 7'd3;
      step();
      arvalid = 0;
      check("raw_model", ref_mem[3], 64'hA5);
      drain();

`ifdef RAM_HS_WSTRB_EN
      wvalid = 1; waddr = 7'd0; wdata = '0; wstrb = 4'b1111;
      step();
      wdata = '1; wstrb = 4'b0101;
      step();
      wvalid = 0; wstrb = '1; arvalid = 1; araddr = 7'd0;
      step();
      arvalid = 0;
      check("wstrb_model", ref_mem[0], 64'h0000_FFFF_0000_FFFF);
      drain();
`endif

      // reset with two reads in flight
      rready = 0; arvalid = 1; araddr = 7'd10;
      step();
      araddr = 7'd11;
      step();
      arvalid = 0;
      rst = 1;
      sb.delete();
      repeat (2) step();
      rst = 0;
      rready = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check("post_rst_rvalid", W'(rvalid), W'(0));
         check("post_rst_rd_cnt", W'(rd_cnt), W'(0));
         check("post_rst_arready", W'(arready), W'(1));
         @(posedge clk);
         #1;
      end

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         wvalid = ($urandom_range(0, 2) == 0);
         waddr  = ADDR_BIT'($urandom_range(0, NADDR - 1));
         wdata  = rand_word();
`ifdef RAM_HS_WSTRB_EN
         wstrb  = SRAM_BYTE'($urandom);
`endif
         arvalid = ($urandom_range(0, 1) == 1);
         araddr  = ADDR_BIT'($urandom_range(0, NADDR - 1));
         rready  = ($urandom_range(0, 3) != 0);
         step();
      end
      wstrb = '1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
